// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: RV32I funct3 encodings, the
// controller state type, the fault classification type and the request
// decode helpers (illegal funct3, misalignment, fault priority).
// -----------------------------------------------------------------------------
package lsu_pkg;

  // RV32I load/store funct3 encodings (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_ILLEGAL    = 2'd1,
    FAULT_MISALIGNED = 2'd2,
    FAULT_ACCESS     = 2'd3
  } lsu_fault_e;

  // Stores accept only B/H/W; loads additionally accept BU/HU.
  function automatic logic lsu_is_illegal(input logic is_store, input logic [2:0] funct3);
    logic ill;
    if (is_store) begin
      case (funct3)
        F3_B, F3_H, F3_W: ill = 1'b0;
        default:          ill = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ill = 1'b0;
        default:                        ill = 1'b1;
      endcase
    end
    return ill;
  endfunction

  // Halves need addr[0] = 0, words need addr[1:0] = 0; bytes never fault.
  function automatic logic lsu_is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = lane[0];
      F3_W:        mis = (lane != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Exactly one fault is reported: illegal > misaligned > access.
  function automatic lsu_fault_e lsu_fault_sel(input logic ill, input logic mis, input logic acc);
    lsu_fault_e f;
    if (ill) begin
      f = FAULT_ILLEGAL;
    end else if (mis) begin
      f = FAULT_MISALIGNED;
    end else if (acc) begin
      f = FAULT_ACCESS;
    end else begin
      f = FAULT_NONE;
    end
    return f;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the load/store unit.
//   word_i        : word read from memory
//   wdata_i       : store data (low byte/half used for SB/SH)
//   lane_i        : addr[1:0] of the request
//   funct3_i      : RV32I funct3 of the request
//   load_data_o   : selected byte/half/word, sign- or zero-extended
//   store_data_o  : word_i with the addressed lane(s) replaced by wdata_i
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  logic [31:0] byte_shift_s;
  logic [31:0] half_shift_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Halves use only addr[1]; addr[0] is known zero for legal halves.
  assign byte_shift_s = word_i >> {lane_i, 3'b000};
  assign half_shift_s = word_i >> {lane_i[1], 4'b0000};
  assign byte_s       = byte_shift_s[7:0];
  assign half_s       = half_shift_s[15:0];

  // Load extraction with sign/zero extension
  always_comb begin
    load_data_o = 32'h0000_0000;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data_o = {24'h00_0000, byte_s};
      F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data_o = {16'h0000, half_s};
      F3_W:    load_data_o = word_i;
      default: load_data_o = 32'h0000_0000;
    endcase
  end

  // Store merge: replace the addressed lane(s) of the read word
  always_comb begin
    store_data_o = word_i;
    case (funct3_i)
      F3_B: store_data_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (lane_i[1]) begin
          store_data_o = {wdata_i[15:0], word_i[15:0]};
        end else begin
          store_data_o = {word_i[31:16], wdata_i[15:0]};
        end
      end
      F3_W:    store_data_o = wdata_i;
      default: store_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I load/store unit between execute stage and a word-addressed memory with
// combinational read data. Sub-word stores are read-modify-write; loads are
// lane-extracted and extended. Misaligned and illegal requests are answered
// without any memory access.
//
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata : request fields, latched on accept
//   resp_valid              : one-cycle completion pulse
//   resp_rdata              : extended load data (0 for stores/faults)
//   resp_misaligned/illegal/access_fault : fault flags, at most one set
//   mem_address             : aligned word address in READ/WRITE, else 0
//   mem_write_data/enable   : write port (enable gated by reset_n)
//   mem_read_data           : combinational memory read data
//
// Configuration macro LSU_BOUNDS_CHECK_EN: when defined, aligned legal
// requests with addr[31:2] >= WORDS report resp_access_fault instead of
// touching memory. When undefined the flag stays 0 and addresses wrap in
// the memory.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic        resp_access_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  if (WORDS < 1) begin : g_words_check
    $error("load_store_unit: WORDS must be at least 1");
  end

  lsu_state_e  state_q;
  logic        ready_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_mis_q;
  logic        resp_ill_q;
  logic        resp_af_q;

  logic        ill_s;
  logic        mis_s;
  logic        acc_fault_s;
  lsu_fault_e  fault_d;
  logic [31:0] load_data_s;
  logic [31:0] store_data_s;

  assign ill_s = lsu_is_illegal(req_write, req_funct3);
  assign mis_s = lsu_is_misaligned(req_funct3, req_addr[1:0]);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic [29:0] WORD_LIMIT = 30'(WORDS);
  assign acc_fault_s = (req_addr[31:2] >= WORD_LIMIT);
`else
  assign acc_fault_s = 1'b0;
`endif

  assign fault_d = lsu_fault_sel(ill_s, mis_s, acc_fault_s);

  lsu_align u_align (
    .word_i       (mem_read_data),
    .wdata_i      (wdata_q),
    .lane_i       (lane_q),
    .funct3_i     (funct3_q),
    .load_data_o  (load_data_s),
    .store_data_o (store_data_s)
  );

  // Controller FSM with registered handshake, memory and response outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ready_q       <= 1'b1;
      write_q       <= 1'b0;
      funct3_q      <= 3'b000;
      lane_q        <= 2'b00;
      wdata_q       <= 32'h0000_0000;
      mem_address_q <= 32'h0000_0000;
      mem_wdata_q   <= 32'h0000_0000;
      mem_we_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0000_0000;
      resp_mis_q    <= 1'b0;
      resp_ill_q    <= 1'b0;
      resp_af_q     <= 1'b0;
    end else begin
      // Pulsed/phase-local outputs fall back to 0 unless a state sets them.
      mem_address_q <= 32'h0000_0000;
      mem_wdata_q   <= 32'h0000_0000;
      mem_we_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0000_0000;
      resp_mis_q    <= 1'b0;
      resp_ill_q    <= 1'b0;
      resp_af_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ready_q  <= 1'b0;
            write_q  <= req_write;
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (fault_d != FAULT_NONE) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_ill_q   <= (fault_d == FAULT_ILLEGAL);
              resp_mis_q   <= (fault_d == FAULT_MISALIGNED);
              resp_af_q    <= (fault_d == FAULT_ACCESS);
            end else if (!req_write || (req_funct3 != F3_W)) begin
              // Loads and sub-word stores need the current word first.
              state_q       <= READ;
              mem_address_q <= {req_addr[31:2], 2'b00};
            end else begin
              state_q       <= WRITE;
              mem_address_q <= {req_addr[31:2], 2'b00};
              mem_wdata_q   <= req_wdata;
              mem_we_q      <= 1'b1;
            end
          end
        end
        READ: begin
          if (!write_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data_s;
          end else begin
            state_q       <= WRITE;
            mem_address_q <= mem_address_q;
            mem_wdata_q   <= store_data_s;
            mem_we_q      <= 1'b1;
          end
        end
        WRITE: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready         = ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = resp_rdata_q;
  assign resp_misaligned   = resp_mis_q;
  assign resp_illegal      = resp_ill_q;
  assign resp_access_fault = resp_af_q;
  assign mem_address       = mem_address_q;
  assign mem_write_data    = mem_wdata_q;
  // A reset asserted during WRITE must suppress the strobe immediately.
  assign mem_write_enable  = mem_we_q & reset_n;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the core's execute stage and the word-addressed data memory.
- Accepts RV32I load/store requests: byte, halfword and word, signed and unsigned.
- Always drives word-aligned addresses to memory.
- Performs read-modify-write for sub-word stores and sign/zero extension for loads.
- Flags misaligned accesses and illegal funct3 codes without touching memory.

Parameters:
WORDS, 64, data memory depth in 32-bit words; must match the attached memory.

Ports:
clk  input  1  clock; all state changes on rising edge
reset_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit idle and able to accept a request
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  byte address
req_wdata  input  32  store data; low byte/half used for SB/SH
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load result; 0 for stores and faults
resp_misaligned  output  1  valid with resp_valid
resp_illegal  output  1  illegal funct3; valid with resp_valid
resp_access_fault  output  1  out-of-range address (see Optional Feature)
mem_address  output  32  {addr[31:2],2'b00}
mem_write_data  output  32  full word to write
mem_write_enable  output  1  write strobe
mem_read_data  input  32  combinational read data from memory

Behaviour:
- Clocking and reset: single clock clk; reset_n synchronous, active-low.
- On reset: state IDLE; resp_valid, resp_rdata, all fault flags, mem_write_enable, mem_write_data, mem_address = 0.
- Reset mid-operation abandons the request with no response. mem_write_enable is gated low combinationally while reset_n = 0.
- req_ready = (state == IDLE). A request is accepted on a cycle with req_valid && req_ready. Accepting latches write, funct3, addr and wdata.
- States and transitions:
  - IDLE: on accept:
    - funct3 illegal, or misaligned (half with addr[0] = 1; word with addr[1:0] != 0) -> RESP with the matching flag.
    - Else load or SB/SH -> READ.
    - Else SW -> WRITE.
  - READ: drive mem_address and register mem_read_data.
    - Load -> RESP.
    - Store -> WRITE.
  - WRITE: mem_write_enable = 1 for exactly this cycle.
    - mem_write_data = req_wdata for SW, or the read word with the selected byte/half lanes replaced. Lane = addr[1:0] for bytes, addr[1] for halves.
    - Next -> RESP.
  - RESP: resp_valid = 1 with result/flags registered; next -> IDLE.
- Latency from accept edge T:
  - LW/LH/LB and SW: resp_valid in cycle T+2.
  - SB/SH: resp_valid in cycle T+3.
  - Fault: resp_valid in cycle T+1.
  - Next accept is possible in the cycle after RESP.
- Load extract: select byte/half by lane. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: anything other than 000/001/010.
  - Illegal takes priority over misaligned; only one flag is set per response.
- mem_address holds the latched aligned address in READ and WRITE, and 0 elsewhere.
- No response backpressure. The consumer must take resp_valid when it pulses.

Optional Feature:
LSU_BOUNDS_CHECK_EN
- Defined: an aligned-legal request with addr[31:2] >= WORDS goes IDLE -> RESP with resp_access_fault = 1 and no memory access. Priority: illegal > misaligned > access fault.
- Undefined: resp_access_fault is tied 0. Addresses are passed through and wrap in memory via the low index bits.

Decomposition:
- lsu_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, READ, WRITE, RESP.
  - Fault-priority helper function.
- Sub-module lsu_align: purely combinational. load_extract(word, lane, funct3) and store_merge(word, wdata, lane, funct3). Instantiated once in load_store_unit.

Test Plan:
Memory word 0x10 preset to 0x8899AABB.
- LB 0x13 -> resp_rdata 0xFFFFFF88 at T+2; LBU 0x13 -> 0x00000088; no mem_write_enable.
- SB 0x11 wdata 0x0000005C -> single write pulse at T+2 with mem_write_data 0x88995CBB at mem_address 0x10; resp_valid at T+3.
- SH 0x12 wdata 0xFFFF1234 -> word 0x1234AABB. Then LH 0x12 -> 0x00001234; LW 0x10 -> 0x1234AABB.
- LW 0x16 -> resp_misaligned = 1 at T+1, rdata 0. SH 0x13 -> misaligned, no write. funct3 011 load -> resp_illegal = 1 only.
- Hold req_valid through an SB -> req_ready low T+1..T+3; second request accepted at T+4. Reset_n low during WRITE -> no write pulse, no resp_valid, req_ready = 1 after the reset edge.
- With LSU_BOUNDS_CHECK_EN, WORDS = 64: LW 0x100 -> resp_access_fault = 1, no memory access. Without the macro: normal access, flag 0.
